// File: rtl/fifo_wr_arbiter.sv
// Round-robin write arbiter in front of a single FIFO write port.
// An owner is picked in IDLE and then keeps the port for up to BURST_MAX transfers.
module fifo_wr_arbiter #(
   parameter int NUM_REQ    = 4,
   parameter int DATA_WIDTH = 8,
   parameter int BURST_MAX  = 4,
   localparam int ID_W      = $clog2(NUM_REQ)
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_REQ-1:0]            req_valid,
   input  logic [NUM_REQ*DATA_WIDTH-1:0] req_data,
   output logic [NUM_REQ-1:0]            req_ready,
   input  logic                          fifo_full,
   output logic                          fifo_wr_en,
   output logic [DATA_WIDTH-1:0]         fifo_din,
   output logic                          grant_valid,
   output logic [ID_W-1:0]               grant_id,
   output logic [15:0]                   stall_cnt
);

   typedef enum logic {IDLE = 1'b0, OWN = 1'b1} state_t;

   localparam logic [3:0] BURST_LAST = 4'(BURST_MAX - 1);

   state_t          state_q;
   logic [ID_W-1:0] grant_id_q;
   logic [ID_W-1:0] rr_ptr_q;
   logic [ID_W-1:0] rr_ptr_d;
   logic [3:0]      burst_cnt_q;
   logic [15:0]     stall_cnt_q;
   logic [15:0]     stall_cnt_d;
   logic [ID_W-1:0] pick_id;
   logic            pick_found;
   logic            owner_valid;
   logic            xfer;

   // First valid requester at or after rr_ptr, wrapping modulo NUM_REQ.
   always_comb begin
      pick_id    = rr_ptr_q;
      pick_found = 1'b0;
      for (int k = 0; k < NUM_REQ; k++) begin
         if (!pick_found && req_valid[(int'(rr_ptr_q) + k) % NUM_REQ]) begin
            pick_id    = ID_W'((int'(rr_ptr_q) + k) % NUM_REQ);
            pick_found = 1'b1;
         end else begin
            pick_found = pick_found;
         end
      end
   end

   assign owner_valid = req_valid[grant_id_q];
   assign xfer        = (state_q == OWN) && owner_valid && !fifo_full;
   assign rr_ptr_d    = (grant_id_q == ID_W'(NUM_REQ - 1)) ? ID_W'(0) : grant_id_q + ID_W'(1);
   assign stall_cnt_d = (stall_cnt_q == 16'hFFFF) ? stall_cnt_q : stall_cnt_q + 16'd1;

   // Write port outputs follow the owner combinationally; state reset clears them at once.
   always_comb begin
      req_ready = '0;
      if (xfer) begin
         req_ready[grant_id_q] = 1'b1;
      end else begin
         req_ready = '0;
      end
      if (state_q == OWN) begin
         fifo_din = req_data[int'(grant_id_q)*DATA_WIDTH +: DATA_WIDTH];
      end else begin
         fifo_din = '0;
      end
   end

   assign fifo_wr_en  = xfer;
   assign grant_valid = (state_q == OWN);
   assign grant_id    = grant_id_q;
   assign stall_cnt   = stall_cnt_q;

   // Grant FSM with burst and backpressure bookkeeping.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         grant_id_q  <= '0;
         rr_ptr_q    <= '0;
         burst_cnt_q <= 4'd0;
         stall_cnt_q <= 16'd0;
      end else begin
         case (state_q)
            IDLE: begin
               if (pick_found) begin
                  grant_id_q  <= pick_id;
                  burst_cnt_q <= 4'd0;
                  state_q     <= OWN;
               end
            end
            OWN: begin
               if (!owner_valid) begin
                  state_q  <= IDLE;
                  rr_ptr_q <= rr_ptr_d;
               end else if (fifo_full) begin
                  stall_cnt_q <= stall_cnt_d;
               end else begin
                  burst_cnt_q <= burst_cnt_q + 4'd1;
                  if (burst_cnt_q == BURST_LAST) begin
                     state_q  <= IDLE;
                     rr_ptr_q <= rr_ptr_d;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule

// File: doc/fifo_wr_arbiter.md
FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 Parameter NUM_REQ, default 4: number of write requesters, 2..8.
REQ-002 Parameter DATA_WIDTH, default 8: data width, equal to the downstream FIFO DATA_WIDTH.
REQ-003 Parameter BURST_MAX, default 4: maximum transfers per grant, 1..16.
REQ-004 Localparam ID_W = $clog2(NUM_REQ).
REQ-005 Port clk  input  1  sole clock; all state updates on its rising edge.
REQ-006 Port rst  input  1  reset; one clock, reset asynchronous and active-high.
REQ-007 Port req_valid  input  NUM_REQ  per-requester data-valid.
REQ-008 Port req_data  input  NUM_REQ*DATA_WIDTH  requester i data at bits [i*DATA_WIDTH +: DATA_WIDTH].
REQ-009 Port req_ready  output  NUM_REQ  per-requester accept; one-hot or zero.
REQ-010 Port fifo_full  input  1  FIFO full flag.
REQ-011 Port fifo_wr_en  output  1  FIFO write enable.
REQ-012 Port fifo_din  output  DATA_WIDTH  FIFO write data.
REQ-013 Port grant_valid  output  1  a requester currently owns the FIFO write port.
REQ-014 Port grant_id  output  ID_W  index of current owner.
REQ-015 Port stall_cnt  output  16  saturating count of backpressure cycles.

Function
REQ-016 FSM states IDLE and OWN; grant_valid SHALL be 1 exactly in OWN.
REQ-017 IDLE, no req_valid bit set: remain IDLE.
REQ-018 IDLE, any req_valid set: select first set bit searching from rr_ptr upward, modulo NUM_REQ; register it into grant_id; enter OWN next cycle (one-cycle arbitration latency).
REQ-019 In OWN, transfer condition xfer = req_valid[grant_id] && !fifo_full.
REQ-020 req_ready[grant_id] = xfer, combinational; all other req_ready bits 0; all bits 0 in IDLE.
REQ-021 fifo_wr_en = xfer; fifo_din = req_data slice of grant_id in OWN, else all zeros.
REQ-022 No write SHALL be issued while fifo_full = 1, even if the FIFO could accept with a same-cycle read.
REQ-023 burst_cnt (4 bits) increments on each xfer; cleared on entry to OWN.
REQ-024 OWN -> IDLE when xfer occurs and burst_cnt == BURST_MAX-1 (burst complete).
REQ-025 OWN -> IDLE when req_valid[grant_id] = 0 (owner withdrew; no transfer that cycle).
REQ-026 OWN with req_valid[grant_id] = 1 and fifo_full = 1: remain OWN, burst_cnt held, stall_cnt += 1.
REQ-027 stall_cnt saturates at 16'hFFFF and does not wrap.
REQ-028 On every OWN -> IDLE transition, rr_ptr <= (grant_id + 1) mod NUM_REQ (wrap NUM_REQ-1 -> 0).
REQ-029 At least one IDLE cycle separates consecutive grants; there are no back-to-back grants.
REQ-030 A requester's valid bit rising while another owns the grant has no effect until the next IDLE arbitration.

Reset
REQ-031 While rst = 1: state IDLE, grant_valid 0, grant_id 0, rr_ptr 0, burst_cnt 0, stall_cnt 0, req_ready all 0, fifo_wr_en 0, fifo_din 0.
REQ-032 Reset asserted mid-burst SHALL abort the burst immediately (asynchronously); no fifo_wr_en after rst rises.
REQ-033 First arbitration after reset release starts search at requester 0.

Verification
REQ-034 NUM_REQ=4, BURST_MAX=4, all req_valid=1, fifo_full=0 for 20 cycles -> grants 0,1,2,3 in order, 4 writes each, 16 writes total, one IDLE cycle between grants.
REQ-035 Only req_valid[2]=1 continuously -> grant_id 2 repeatedly; 4 writes, 1 IDLE cycle, repeat; fifo_din equals req_data slice 2 on every write.
REQ-036 Owner 1 after 1 transfer, fifo_full=1 for 3 cycles -> req_ready and fifo_wr_en 0 for those cycles, grant held, stall_cnt +3; remaining 3 transfers follow, then IDLE.
REQ-037 Owner 3 drops req_valid after 2 transfers, req 0 and 1 valid -> exit to IDLE, rr_ptr wraps to 0, next grant_id 0.
REQ-038 rst=1 asserted during the 3rd transfer of owner 2 -> all outputs 0 immediately; after release with all valid, first grant_id 0.
REQ-039 fifo_full held 1 with owner valid for 65540 cycles -> stall_cnt stops at 16'hFFFF.
